// File: rtl/alu_design.sv
// alu_design: clocked, parameterised ALU with registered outputs.
// Single-cycle operations update the outputs at the edge where they are sampled.
// The two multiply commands go through a short pipeline: operands are captured,
// the product is formed on the next edge, and it is written out one edge later.
module alu_design #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   OPA,
  input  logic [DW-1:0]   OPB,
  input  logic [CW-1:0]   CMD,
  input  logic            MODE,
  input  logic            CE,
  input  logic            CIN,
  input  logic [1:0]      INP_VALID,
  output logic [2*DW-1:0] RES,
  output logic            COUT,
  output logic            OFLOW,
  output logic            ERR,
  output logic            E,
  output logic            G,
  output logic            L
);
  localparam int RW = 2*DW;
  localparam int SW = $clog2(DW);

  // arithmetic command codes (MODE=1)
  localparam logic [CW-1:0] A_ADD  = CW'(0),  A_SUB  = CW'(1),  A_ADDC = CW'(2),
                            A_SUBC = CW'(3),  A_INCA = CW'(4),  A_DECA = CW'(5),
                            A_INCB = CW'(6),  A_DECB = CW'(7),  A_CMP  = CW'(8),
                            A_MULI = CW'(9),  A_MULS = CW'(10), A_SADD = CW'(11),
                            A_SSUB = CW'(12);
  // logical command codes (MODE=0)
  localparam logic [CW-1:0] L_AND  = CW'(0),  L_NAND = CW'(1),  L_OR   = CW'(2),
                            L_NOR  = CW'(3),  L_XOR  = CW'(4),  L_XNOR = CW'(5),
                            L_NOTA = CW'(6),  L_NOTB = CW'(7),  L_SHRA = CW'(8),
                            L_SHLA = CW'(9),  L_SHRB = CW'(10), L_SHLB = CW'(11),
                            L_ROL  = CW'(12), L_ROR  = CW'(13);

  localparam logic [DW:0] ONE = (DW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_M1, S_M2} st_t;

  st_t st_q, st_d;

  logic [RW-1:0] res_q, prod_q, mul_a_q, mul_b_q;
  logic          cout_q, oflow_q, err_q, e_q, g_q, l_q;

  logic [RW-1:0] res_d, ma_d, mb_d;
  logic          cout_d, oflow_d, err_d, e_d, g_d, l_d;
  logic          mul_go, accept, mul_ld, mul_wb;

  logic [DW:0]   a_x, b_x, sa, sb, cin_x, t;
  logic [DW-1:0] lv;
  logic [2*DW-1:0] rot2;
  logic [1:0]    need;
  logic          known;

  // Decode the sampled command into next output values (single-cycle ops)
  // and flag a valid multiply start.
  always_comb begin
    a_x     = {1'b0, OPA};
    b_x     = {1'b0, OPB};
    sa      = {OPA[DW-1], OPA};
    sb      = {OPB[DW-1], OPB};
    cin_x   = {{DW{1'b0}}, CIN};
    t       = '0;
    lv      = '0;
    rot2    = '0;
    need    = 2'b11;
    known   = 1'b1;
    mul_go  = 1'b0;
    cout_d  = 1'b0;
    oflow_d = 1'b0;
    err_d   = 1'b0;
    e_d     = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    ma_d    = RW'(a_x + ONE);
    mb_d    = RW'(b_x + ONE);
    if (MODE) begin
      case (CMD)
        A_ADD:  begin t = a_x + b_x; cout_d = t[DW]; end
        A_SUB:  begin t = a_x - b_x; oflow_d = (OPA < OPB); end
        A_ADDC: begin t = a_x + b_x + cin_x; cout_d = t[DW]; end
        A_SUBC: begin t = a_x - b_x - cin_x; oflow_d = (a_x < (b_x + cin_x)); end
        A_INCA: begin need = 2'b01; t = a_x + ONE; end
        A_DECA: begin need = 2'b01; t = a_x - ONE; end
        A_INCB: begin need = 2'b10; t = b_x + ONE; end
        A_DECB: begin need = 2'b10; t = b_x - ONE; end
        A_CMP:  begin e_d = (OPA == OPB); g_d = (OPA > OPB); l_d = (OPA < OPB); end
        A_MULI: mul_go = 1'b1;
        A_MULS: begin
          mul_go = 1'b1;
          ma_d   = RW'({OPA[DW-2:0], 1'b0});
          mb_d   = RW'(OPB);
        end
        A_SADD: begin
          t       = sa + sb;
          oflow_d = (OPA[DW-1] == OPB[DW-1]) && (t[DW-1] != OPA[DW-1]);
          e_d     = (OPA == OPB);
          g_d     = ($signed(OPA) > $signed(OPB));
          l_d     = ($signed(OPA) < $signed(OPB));
        end
        A_SSUB: begin
          t       = sa - sb;
          oflow_d = (OPA[DW-1] != OPB[DW-1]) && (t[DW-1] != OPA[DW-1]);
          e_d     = (OPA == OPB);
          g_d     = ($signed(OPA) > $signed(OPB));
          l_d     = ($signed(OPA) < $signed(OPB));
        end
        default: known = 1'b0;
      endcase
    end else begin
      case (CMD)
        L_AND:  lv = OPA & OPB;
        L_NAND: lv = ~(OPA & OPB);
        L_OR:   lv = OPA | OPB;
        L_NOR:  lv = ~(OPA | OPB);
        L_XOR:  lv = OPA ^ OPB;
        L_XNOR: lv = ~(OPA ^ OPB);
        L_NOTA: begin need = 2'b01; lv = ~OPA; end
        L_NOTB: begin need = 2'b10; lv = ~OPB; end
        L_SHRA: begin need = 2'b01; lv = OPA >> 1; end
        L_SHLA: begin need = 2'b01; lv = OPA << 1; end
        L_SHRB: begin need = 2'b10; lv = OPB >> 1; end
        L_SHLB: begin need = 2'b10; lv = OPB << 1; end
        // rotate via a doubled copy; out-of-range amount flags ERR but keeps the value
        L_ROL: begin
          rot2  = {OPA, OPA} << OPB[SW-1:0];
          lv    = rot2[2*DW-1:DW];
          err_d = |OPB[DW-1:SW];
        end
        L_ROR: begin
          rot2  = {OPA, OPA} >> OPB[SW-1:0];
          lv    = rot2[DW-1:0];
          err_d = |OPB[DW-1:SW];
        end
        default: known = 1'b0;
      endcase
    end
    res_d = MODE ? RW'(t) : RW'(lv);
    // bad command or missing operand: only ERR survives, no multiply launch
    if (!known || ((INP_VALID & need) != need)) begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      e_d     = 1'b0;
      g_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b1;
      mul_go  = 1'b0;
    end
  end

  // Multiply sequencer state register
  always_ff @(posedge CLK) begin
    if (!RST)    st_q <= S_IDLE;
    else if (CE) st_q <= st_d;
  end

  // Multiply sequencer next state: capture -> product -> writeback
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (mul_go) st_d = S_M1;
      S_M1:    st_d = S_M2;
      S_M2:    st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Multiply sequencer outputs
  always_comb begin
    accept = (st_q == S_IDLE);
    mul_ld = (st_q == S_M1);
    mul_wb = (st_q == S_M2);
  end

  // Datapath registers: single-cycle writeback, multiply capture/product/writeback
  always_ff @(posedge CLK) begin
    if (!RST) begin
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      err_q   <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
    end else if (CE) begin
      if (accept && mul_go) begin
        mul_a_q <= ma_d;
        mul_b_q <= mb_d;
      end else if (accept) begin
        res_q   <= res_d;
        cout_q  <= cout_d;
        oflow_q <= oflow_d;
        err_q   <= err_d;
        e_q     <= e_d;
        g_q     <= g_d;
        l_q     <= l_d;
      end
      if (mul_ld) prod_q <= mul_a_q * mul_b_q;
      if (mul_wb) begin
        res_q   <= prod_q;
        cout_q  <= 1'b0;
        oflow_q <= 1'b0;
        err_q   <= 1'b0;
        e_q     <= 1'b0;
        g_q     <= 1'b0;
        l_q     <= 1'b0;
      end
    end
  end

  assign RES   = res_q;
  assign COUT  = cout_q;
  assign OFLOW = oflow_q;
  assign ERR   = err_q;
  assign E     = e_q;
  assign G     = g_q;
  assign L     = l_q;
endmodule

// File: tb/tb_alu_design.sv
// tb_alu_design: directed cases plus randomized traffic against a behavioural
// model computed with plain integer arithmetic and a cycle countdown for multiply.
module tb_alu_design;
  localparam int DW = 8;
  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RST, MODE, CE, CIN;
  logic [DW-1:0]   OPA, OPB;
  logic [CW-1:0]   CMD;
  logic [1:0]      INP_VALID;
  logic [2*DW-1:0] RES;
  logic            COUT, OFLOW, ERR, E, G, L;

  alu_design #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE),
    .CE(CE), .CIN(CIN), .INP_VALID(INP_VALID), .RES(RES), .COUT(COUT),
    .OFLOW(OFLOW), .ERR(ERR), .E(E), .G(G), .L(L)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] res;
    logic cout, oflow, err, e, g, l;
  } out_t;

  out_t exp_o = '0;
  out_t pend  = '0;
  int   busy  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t act();
    out_t o;
    o = {RES, COUT, OFLOW, ERR, E, G, L};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: what one accepted command produces, straight from the operation table.
  function automatic out_t ref_op(input int mode, cmd, a, b, cin, iv, output bit is_mul);
    out_t o;
    int need, s, amt;
    bit def;
    o = '0; need = 3; def = 1; is_mul = 0;
    amt = b % 8;
    if (mode != 0) begin
      case (cmd)
        0:  begin s = a + b;       o.res = 16'(s); o.cout = (s >= 256); end
        1:  begin o.res = 16'((a - b) & 'h1FF); o.oflow = (a < b); end
        2:  begin s = a + b + cin; o.res = 16'(s); o.cout = (s >= 256); end
        3:  begin o.res = 16'((a - b - cin) & 'h1FF); o.oflow = (a < b + cin); end
        4:  begin need = 1; o.res = 16'(a + 1); end
        5:  begin need = 1; o.res = 16'((a - 1) & 'h1FF); end
        6:  begin need = 2; o.res = 16'(b + 1); end
        7:  begin need = 2; o.res = 16'((b - 1) & 'h1FF); end
        8:  begin o.e = (a == b); o.g = (a > b); o.l = (a < b); end
        9:  begin is_mul = 1; o.res = 16'(((a + 1) * (b + 1)) & 'hFFFF); end
        10: begin is_mul = 1; o.res = 16'(((a * 2) % 256) * b); end
        11, 12: begin
          s = (cmd == 11) ? sx(a) + sx(b) : sx(a) - sx(b);
          o.res   = 16'(s & 'h1FF);
          o.oflow = (s > 127) || (s < -128);
          o.e = (a == b); o.g = (sx(a) > sx(b)); o.l = (sx(a) < sx(b));
        end
        default: def = 0;
      endcase
    end else begin
      case (cmd)
        0:  o.res = 16'(a & b);
        1:  o.res = 16'(~(a & b) & 'hFF);
        2:  o.res = 16'(a | b);
        3:  o.res = 16'(~(a | b) & 'hFF);
        4:  o.res = 16'(a ^ b);
        5:  o.res = 16'(~(a ^ b) & 'hFF);
        6:  begin need = 1; o.res = 16'(~a & 'hFF); end
        7:  begin need = 2; o.res = 16'(~b & 'hFF); end
        8:  begin need = 1; o.res = 16'(a / 2); end
        9:  begin need = 1; o.res = 16'((a * 2) & 'hFF); end
        10: begin need = 2; o.res = 16'(b / 2); end
        11: begin need = 2; o.res = 16'((b * 2) & 'hFF); end
        12: begin o.res = 16'(((a << amt) | (a >> (8 - amt))) & 'hFF); o.err = (b >= 8); end
        13: begin o.res = 16'(((a >> amt) | (a << (8 - amt))) & 'hFF); o.err = (b >= 8); end
        default: def = 0;
      endcase
    end
    if (!def || ((iv & need) != need)) begin
      o = '0; o.err = 1; is_mul = 0;
    end
    return o;
  endfunction

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input int rst, ce, mode, cmd, a, b, cin, iv);
    out_t o;
    bit   m;
    RST = rst[0]; CE = ce[0]; MODE = mode[0]; CMD = cmd[CW-1:0];
    OPA = a[DW-1:0]; OPB = b[DW-1:0]; CIN = cin[0]; INP_VALID = iv[1:0];
    @(posedge CLK);
    if (rst == 0) begin
      exp_o = '0; busy = 0;
    end else if (ce != 0) begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) exp_o = pend;
      end else begin
        o = ref_op(mode, cmd, a, b, cin, iv, m);
        if (m) begin pend = o; busy = 2; end
        else exp_o = o;
      end
    end
    #1;
    chk("model", 32'(act()), 32'(exp_o));
  endtask

  initial begin
    // reset with CE low then high, random operands
    step(0, 0, 1, 0, $urandom_range(255), $urandom_range(255), 0, 3);
    step(0, 1, 1, 0, $urandom_range(255), $urandom_range(255), 0, 3);
    chk("reset", 32'(act()), 32'h0);

    step(1, 1, 1, 0, 200, 100, 0, 3);
    chk("add_res", 32'(RES), 300);
    chk("add_cout", 32'(COUT), 1);

    step(1, 1, 1, 1, 5, 10, 0, 3);
    chk("sub_res", 32'(RES), 'h1FB);
    chk("sub_ofl", 32'(OFLOW), 1);

    step(1, 1, 1, 3, 10, 3, 1, 3);
    chk("subc_res", 32'(RES), 6);
    chk("subc_ofl", 32'(OFLOW), 0);

    step(1, 1, 1, 8, 7, 7, 0, 3);
    chk("cmp_eq", 32'({E, G, L}), 3'b100);
    step(1, 1, 1, 8, 9, 3, 0, 3);
    chk("cmp_gt", 32'({E, G, L}), 3'b010);

    step(1, 1, 1, 11, 'h7F, 'h01, 0, 3);
    chk("sadd_ofl", 32'(OFLOW), 1);
    chk("sadd_res", 32'(RES), 'h080);

    // multiply latency: held for two edges, result on the third
    step(1, 1, 1, 9, 3, 4, 0, 3);
    chk("mul_n", 32'(RES), 'h080);
    step(1, 1, 1, 0, 1, 1, 0, 3);
    chk("mul_n1", 32'(RES), 'h080);
    step(1, 1, 1, 0, 1, 1, 0, 3);
    chk("mul_n2", 32'(RES), 20);
    step(1, 1, 1, 0, 1, 1, 0, 3);
    chk("mul_n3", 32'(RES), 2);

    // reset aborts an in-flight multiply
    step(1, 1, 1, 9, 5, 5, 0, 3);
    step(0, 1, 1, 0, 1, 1, 0, 3);
    chk("mul_rst", 32'(act()), 32'h0);
    step(1, 1, 1, 8, 0, 0, 0, 3);
    chk("mul_nolate", 32'(act()), 32'h4);

    step(1, 1, 0, 12, 'h81, 1, 0, 3);
    chk("rol_ok", 32'({RES, ERR}), {16'h03, 1'b0});
    step(1, 1, 0, 12, 'h81, 'h11, 0, 3);
    chk("rol_err", 32'({RES, ERR}), {16'h03, 1'b1});

    step(1, 1, 1, 0, 4, 4, 0, 1);
    chk("add_iv01", 32'(act()), 32'h8);
    step(1, 1, 1, 0, 4, 4, 0, 3);
    step(1, 1, 1, 14, 4, 4, 0, 3);
    chk("bad_cmd", 32'(act()), 32'h8);
    step(1, 0, 1, 0, 50, 60, 0, 3);
    chk("ce_hold", 32'(act()), 32'h8);

    // randomized traffic, mostly valid operands, occasional reset and CE drop
    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(49) != 0), int'($urandom_range(7) != 0),
           int'($urandom_range(1)), int'($urandom_range(15)),
           int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(1)),
           ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_design.md
# alu_design

Clocked, parameterised arithmetic/logic unit. Operands are sampled on the rising clock edge. A command is decoded using MODE (arithmetic or logical) and CMD. The block returns a registered result, carry/overflow, compare and error flags. It is a standalone datapath block, driven over the `alu_if` interface by the verification environment, and sits behind a command source in the system.

## Interface
- DW, 8, operand width
- CW, 4, command width
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; synchronous, active-low
- OPA  in  DW  operand A
- OPB  in  DW  operand B
- CMD  in  CW  command code
- MODE  in  1  1 = arithmetic, 0 = logical
- CE  in  1  clock enable; when 0, all outputs hold
- CIN  in  1  carry/borrow input
- INP_VALID  in  2  operand valid flags: bit0 = OPA valid, bit1 = OPB valid
- RES  out  2*DW  result, zero-extended
- COUT  out  1  carry out
- OFLOW  out  1  overflow / borrow
- ERR  out  1  error
- E, G, L  out  1 each  equal / greater / less

## Operation
- Reset: RST=0 at a rising edge clears all outputs to 0 and clears the multiply pipeline, regardless of CE.
- Each accepted operation writes every output. Flags that the operation does not define are driven 0.
- Operand requirements:
  - Two-operand commands need INP_VALID=11.
  - A-only commands need bit0=1.
  - B-only commands need bit1=1.
  - If the requirement is violated: ERR=1, RES=0, other flags 0.
- Undefined CMD for the current MODE gives ERR=1, RES=0.

MODE=1 (arithmetic), where n = DW:
- 0 ADD: RES=A+B; COUT=sum bit n.
- 1 SUB: RES[n:0]=A−B mod 2^(n+1); OFLOW=(A<B).
- 2 ADD_CIN: RES=A+B+CIN; COUT as ADD.
- 3 SUB_CIN: RES=A−B−CIN, same width rule as SUB; OFLOW=(A<B+CIN).
- 4 INC_A, 5 DEC_A: A±1, (n+1)-bit result, A-only.
- 6 INC_B, 7 DEC_B: B±1, (n+1)-bit result, B-only.
- 8 CMP: unsigned compare sets exactly one of E/G/L; RES=0.
- 9 MUL_INC: RES=(A+1)*(B+1), 2n bits.
- 10 MUL_SHL: RES=((A<<1) mod 2^n)*B.
- 11 SADD: RES = signed A+B, sign-extended into n+1 bits. OFLOW = two's-complement overflow of the n-bit sum. E/G/L from the signed compare of A and B.
- 12 SSUB: as SADD, for A−B.

MODE=0 (logical), result in RES[n-1:0]:
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- 6 NOT_A (A-only), 7 NOT_B (B-only).
- 8 SHR1_A, 9 SHL1_A (A-only).
- 10 SHR1_B, 11 SHL1_B (B-only).
- 12 ROL_A_B, 13 ROR_A_B: rotate A by OPB[log2(n)-1:0]. If any higher bit of OPB is nonzero, ERR=1 and RES still carries the rotated value.

## Timing
- CE=1 and no multiply busy: inputs are sampled at edge N and outputs update at edge N. The result is visible until the next update.
- Multiply (MODE=1, CMD 9/10) is sampled at edge N:
  - Outputs hold their previous values at edges N and N+1.
  - RES/flags update at edge N+2.
  - Inputs arriving at edges N+1 and N+2 are ignored; the next command is accepted at edge N+3.
  - A multiply that fails the operand check reports ERR at edge N, with no pipeline.
- CE=0: nothing is sampled and outputs hold. A multiply in flight is paused and resumes when CE returns to 1.
- Reset during a multiply aborts it; outputs are 0 at that edge.
- CE is ignored while RST=0.

## Test plan
- Reset: drive RST=0 for 2 edges while OPA/OPB are random → all outputs 0. Then ADD 200+100, INP_VALID=11, CE=1 → RES=300, COUT=1 at the same edge.
- SUB 5−10 → RES=0x1FB, OFLOW=1. SUB_CIN 10−3, CIN=1 → RES=6, OFLOW=0.
- CMP (7,7) → E=1, G=0, L=0. CMP (9,3) → G=1. SADD 0x7F+0x01 → OFLOW=1.
- MUL_INC with A=3, B=4 → RES=20 exactly 2 edges after sampling, previous RES held at the intermediate edges. Assert RST=0 mid-multiply → RES=0 and no late result.
- ROL_A_B with A=0x81, B=1 → RES=0x03, ERR=0. With B=0x11 → RES=0x03, ERR=1.
- Errors:
  - ADD with INP_VALID=01 → ERR=1, RES=0.
  - MODE=1, CMD=14 → ERR=1.
  - CE=0 with new stimulus → outputs unchanged.
